// File: rtl/turbo_encoder.sv
// turbo_encoder: rate-1/3 8-state turbo encoder, 24-bit block to 84-bit frame sent as four 21-bit words.
module turbo_encoder (
    input  logic        clk_p_i,
    input  logic        reset_p_i,
    input  logic        start_i,
    input  logic [23:0] data_i,
    output logic        start_o,
    output logic [20:0] data_o,
    output logic        done_o,
    output logic        busy_o
);
    typedef enum logic [1:0] {IDLE, ENC, TAIL, SEND} state_t;
    state_t      state_q;
    logic [4:0]  cnt_q, pi_q, pi_d;
    logic [5:0]  pi_sum;
    logic [23:0] blk_q;
    logic [2:0]  s1_q, s2_q, s1_d, s2_d;
    logic [71:0] body_q;
    logic [5:0]  t1_q, t2_q;
    logic [83:0] frame;
    logic [20:0] word;
    logic        tail, accept, u1, u2, a1, a2, z1, z2;
    // State vectors are {s1,s2,s3}; in TAIL u = s2^s3 drives the feedback a to zero
    assign tail   = state_q == TAIL;
    assign u1     = tail ? s1_q[1] ^ s1_q[0] : blk_q[5'd23 - cnt_q];
    assign u2     = tail ? s2_q[1] ^ s2_q[0] : blk_q[5'd23 - pi_q];
    assign a1     = u1 ^ s1_q[1] ^ s1_q[0];
    assign a2     = u2 ^ s2_q[1] ^ s2_q[0];
    assign z1     = a1 ^ s1_q[2] ^ s1_q[0];
    assign z2     = a2 ^ s2_q[2] ^ s2_q[0];
    assign s1_d   = {a1, s1_q[2:1]};
    assign s2_d   = {a2, s2_q[2:1]};
    // pi(k+1) - pi(k) = 12k + 11 mod 24, i.e. alternately 11 and 23
    assign pi_sum = {1'b0, pi_q} + (cnt_q[0] ? 6'd23 : 6'd11);
    assign pi_d   = pi_sum >= 6'd24 ? 5'(pi_sum - 6'd24) : pi_sum[4:0];
    assign frame  = {body_q, t1_q, t2_q};
    assign word   = cnt_q[1:0] == 2'd1 ? frame[62:42] :
                    cnt_q[1:0] == 2'd2 ? frame[41:21] : frame[20:0];
    assign accept = start_i && (state_q == IDLE || (state_q == SEND && cnt_q == 5'd4));
    assign busy_o = state_q != IDLE;
    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pi_q    <= '0;
            blk_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            body_q  <= '0;
            t1_q    <= '0;
            t2_q    <= '0;
            start_o <= 1'b0;
            done_o  <= 1'b0;
            data_o  <= '0;
        end else begin
            start_o <= 1'b0;
            done_o  <= 1'b0;
            data_o  <= '0;
            if (accept) begin
                state_q <= ENC;
                cnt_q   <= '0;
                pi_q    <= '0;
                blk_q   <= data_i;
                s1_q    <= '0;
                s2_q    <= '0;
            end else begin
                case (state_q)
                    ENC: begin
                        s1_q   <= s1_d;
                        s2_q   <= s2_d;
                        pi_q   <= pi_d;
                        body_q <= {body_q[68:0], u1, z1, z2};
                        cnt_q  <= cnt_q == 5'd23 ? 5'd0 : cnt_q + 5'd1;
                        if (cnt_q == 5'd23) state_q <= TAIL;
                    end
                    TAIL: begin
                        s1_q  <= s1_d;
                        s2_q  <= s2_d;
                        t1_q  <= {t1_q[3:0], u1, z1};
                        t2_q  <= {t2_q[3:0], u2, z2};
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd2) begin
                            state_q <= SEND;
                            cnt_q   <= 5'd1;
                            start_o <= 1'b1;
                            data_o  <= frame[83:63];
                        end
                    end
                    SEND: begin
                        if (cnt_q == 5'd4) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            start_o <= 1'b1;
                            data_o  <= word;
                            done_o  <= cnt_q == 5'd3;
                            cnt_q   <= cnt_q + 5'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_turbo_encoder.sv
// tb_turbo_encoder: directed checks of the turbo encoder frame contents and timing.
module tb_turbo_encoder;
    logic        clk_p_i = 1'b0;
    logic        reset_p_i = 1'b0;
    logic        start_i = 1'b0;
    logic [23:0] data_i = '0;
    logic        start_o, done_o, busy_o;
    logic [20:0] data_o;
    int tests = 0;
    int fails = 0;
    localparam logic [83:0] F_ZERO = 84'h0;
    localparam logic [83:0] F_IMP  = {21'h1DB603, 21'h01B603, 21'h01B603, 21'h01BAEB};
    localparam logic [83:0] F_INT  = {21'h032480, 21'h082480, 21'h082480, 21'h083B1B};

    turbo_encoder dut (
        .clk_p_i(clk_p_i), .reset_p_i(reset_p_i), .start_i(start_i), .data_i(data_i),
        .start_o(start_o), .data_o(data_o), .done_o(done_o), .busy_o(busy_o)
    );

    always #5 clk_p_i = ~clk_p_i;

    task automatic issue(input logic [23:0] d);
        @(negedge clk_p_i);
        start_i = 1'b1;
        data_i = d;
        @(posedge clk_p_i);
        #1;
        start_i = 1'b0;
        tests++;
        if (busy_o !== 1'b1) begin
            fails++;
            $display("FAIL issue_busy: got %b want 1", busy_o);
        end
    endtask

    // Checks edges E1..E<stop> after an accepted start at E0
    task automatic watch(input string name, input logic [83:0] f, input int inj,
                         input bit chain, input logic [23:0] nd, input int stop);
        logic [83:0] fv;
        logic [20:0] ew;
        logic es, ed, eb;
        fv = f;
        for (int n = 1; n <= stop; n++) begin
            @(posedge clk_p_i);
            #1;
            es = n >= 27 && n <= 30;
            ed = n == 30;
            eb = n <= 30 || chain;
            ew = es ? fv[83 - 21 * (n - 27) -: 21] : 21'h0;
            tests++;
            if (start_o !== es || done_o !== ed || busy_o !== eb || data_o !== ew) begin
                fails++;
                $display("FAIL %s E%0d: got start=%b done=%b busy=%b data=%h want start=%b done=%b busy=%b data=%h",
                         name, n, start_o, done_o, busy_o, data_o, es, ed, eb, ew);
            end
            if (n == inj - 1) begin
                start_i = 1'b1;
                data_i = 24'hFFFFFF;
            end
            if (n == inj) start_i = 1'b0;
            if (chain && n == 30) begin
                start_i = 1'b1;
                data_i = nd;
            end
            if (n == 31) start_i = 1'b0;
        end
    endtask

    task automatic idle_check(input string name, input int cycles);
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk_p_i);
            #1;
            tests++;
            if (start_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0 || data_o !== 21'h0) begin
                fails++;
                $display("FAIL %s cycle %0d: got start=%b done=%b busy=%b data=%h want all 0",
                         name, n, start_o, done_o, busy_o, data_o);
            end
        end
    endtask

    task automatic test_reset;
        reset_p_i = 1'b1;
        start_i = 1'b1;
        data_i = 24'h800000;
        repeat (3) @(posedge clk_p_i);
        #1;
        reset_p_i = 1'b0;
        start_i = 1'b0;
        tests++;
        if (start_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0 || data_o !== 21'h0) begin
            fails++;
            $display("FAIL reset: got start=%b done=%b busy=%b data=%h want all 0",
                     start_o, done_o, busy_o, data_o);
        end
        idle_check("reset_idle", 35);
    endtask

    task automatic test_zero;
        issue(24'h000000);
        watch("zero", F_ZERO, 0, 1'b0, 24'h0, 31);
    endtask

    task automatic test_impulse;
        issue(24'h800000);
        watch("impulse", F_IMP, 0, 1'b0, 24'h0, 31);
    endtask

    task automatic test_interleaver;
        issue(24'h400000);
        watch("interleave", F_INT, 0, 1'b0, 24'h0, 31);
    endtask

    task automatic test_back_to_back;
        issue(24'h800000);
        watch("busy_ignore", F_IMP, 5, 1'b1, 24'h400000, 31);
        watch("b2b_second", F_INT, 0, 1'b0, 24'h0, 31);
        idle_check("b2b_idle", 3);
    endtask

    task automatic test_reset_mid;
        issue(24'h800000);
        watch("mid_pre", F_IMP, 0, 1'b0, 24'h0, 28);
        reset_p_i = 1'b1;
        @(posedge clk_p_i);
        #1;
        reset_p_i = 1'b0;
        tests++;
        if (start_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0 || data_o !== 21'h0) begin
            fails++;
            $display("FAIL mid_reset: got start=%b done=%b busy=%b data=%h want all 0",
                     start_o, done_o, busy_o, data_o);
        end
        idle_check("mid_idle", 33);
        issue(24'h800000);
        watch("mid_after", F_IMP, 0, 1'b0, 24'h0, 31);
    endtask

    initial begin
        test_reset;
        test_zero;
        test_impulse;
        test_interleaver;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
